// File: rtl/wave_scope_plot.sv
// Triggered, decimated capture of an 8-bit sample stream into a ping-pong line buffer,
// rendered as a connected trace over the incoming HDMI pixel stream.
module wave_scope_plot #(
    parameter int unsigned PLOT_W       = 512,
    parameter int unsigned PLOT_X0      = 64,
    parameter int unsigned PLOT_Y0      = 112,
    parameter int unsigned DECIM        = 1,
    parameter int unsigned TRIG_LEVEL   = 128,
    parameter int unsigned TRIG_TIMEOUT = 4096,
    parameter logic [23:0] TRACE_RGB    = 24'hFFFF00,
    parameter logic [23:0] BG_RGB       = 24'h000000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  sample_in,
    input  logic        sample_valid,
    input  logic        freeze,
    input  logic        frame_start,
    input  logic        pix_de,
    input  logic [11:0] pix_x,
    input  logic [11:0] pix_y,
    input  logic [23:0] pix_rgb_in,
    output logic [23:0] pix_rgb_out,
    output logic        pix_de_out,
    output logic        cap_busy,
    output logic        rec_valid
);

    localparam int unsigned AW = $clog2(PLOT_W);
    localparam int unsigned TW = ($clog2(TRIG_TIMEOUT) > 0) ? $clog2(TRIG_TIMEOUT) : 1;

    localparam logic [AW-1:0] ADDR_LAST = AW'(PLOT_W - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TRIG_TIMEOUT - 1);
    localparam logic [7:0]    DEC_LAST  = 8'(DECIM - 1);
    localparam logic [7:0]    TRIG_LVL  = 8'(TRIG_LEVEL);
    localparam logic [11:0]   X0        = 12'(PLOT_X0);
    localparam logic [11:0]   X_END     = 12'(PLOT_X0 + PLOT_W);
    localparam logic [11:0]   Y0        = 12'(PLOT_Y0);
    localparam logic [11:0]   Y_END     = 12'(PLOT_Y0 + 256);

    typedef enum logic [1:0] {StIdle, StArm, StCapture, StDone} state_e;

    state_e        state_q;
    logic          wr_bank_q;
    logic          rec_valid_q;
    logic [7:0]    dec_cnt_q;
    logic [TW-1:0] tmo_cnt_q;
    logic [7:0]    sample_prev_q;
    logic [AW-1:0] wr_addr_q;

    logic          trig;
    logic          wr_en;
    logic [AW-1:0] wr_addr;

    always_comb begin
        trig    = sample_valid &&
                  (((sample_prev_q < TRIG_LVL) && (sample_in >= TRIG_LVL)) ||
                   (tmo_cnt_q == TMO_LAST));
        wr_en   = ((state_q == StArm) && trig) ||
                  ((state_q == StCapture) && sample_valid && (dec_cnt_q == 8'd0));
        wr_addr = (state_q == StArm) ? '0 : wr_addr_q;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= StIdle;
            wr_bank_q     <= 1'b0;
            rec_valid_q   <= 1'b0;
            dec_cnt_q     <= 8'd0;
            tmo_cnt_q     <= '0;
            sample_prev_q <= 8'd0;
            wr_addr_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tmo_cnt_q <= '0;
                    if (!freeze) state_q <= StArm;
                end
                StArm: begin
                    if (sample_valid) begin
                        sample_prev_q <= sample_in;
                        if (trig) begin
                            state_q   <= StCapture;
                            wr_addr_q <= AW'(1);
                            tmo_cnt_q <= '0;
                            // Trigger sample occupies decimation phase 0.
                            dec_cnt_q <= (DEC_LAST == 8'd0) ? 8'd0 : 8'd1;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + 1'b1;
                        end
                    end
                end
                StCapture: begin
                    if (sample_valid) begin
                        dec_cnt_q <= (dec_cnt_q == DEC_LAST) ? 8'd0 : dec_cnt_q + 8'd1;
                        if (dec_cnt_q == 8'd0) begin
                            if (wr_addr_q == ADDR_LAST) state_q <= StDone;
                            else wr_addr_q <= wr_addr_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (frame_start) begin
                        wr_bank_q   <= ~wr_bank_q;
                        rec_valid_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cap_busy  = (state_q == StArm) || (state_q == StCapture);
    assign rec_valid = rec_valid_q;

    // Ping-pong buffer: bank bit on top, display bank is always the other one.
    logic [7:0]    mem [2*PLOT_W];
    logic [7:0]    rd_data_q;
    logic [AW-1:0] rd_addr;

    assign rd_addr = AW'(pix_x - X0);

    always_ff @(posedge sys_clk) begin
        if (wr_en) mem[{wr_bank_q, wr_addr}] <= sample_in;
        rd_data_q <= mem[{~wr_bank_q, rd_addr}];
    end

    logic        in_win;
    logic        win1_q;
    logic        first1_q;
    logic [7:0]  row1_q;
    logic [23:0] rgb1_q;
    logic        de1_q;
    logic [7:0]  prev_q;
    logic [7:0]  prev_eff;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic        hit;

    assign in_win = pix_de && (pix_x >= X0) && (pix_x < X_END) &&
                    (pix_y >= Y0) && (pix_y < Y_END);

    always_comb begin
        prev_eff = first1_q ? rd_data_q : prev_q;
        lo       = (prev_eff < rd_data_q) ? prev_eff : rd_data_q;
        hi       = (prev_eff < rd_data_q) ? rd_data_q : prev_eff;
        hit      = (row1_q >= lo) && (row1_q <= hi);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            win1_q      <= 1'b0;
            first1_q    <= 1'b0;
            row1_q      <= 8'd0;
            rgb1_q      <= 24'd0;
            de1_q       <= 1'b0;
            prev_q      <= 8'd0;
            pix_rgb_out <= 24'd0;
            pix_de_out  <= 1'b0;
        end else begin
            win1_q   <= in_win;
            first1_q <= (pix_x == X0);
            // Screen rows grow downward; sample value 255 sits on the top row.
            row1_q   <= ~8'(pix_y - Y0);
            rgb1_q   <= pix_rgb_in;
            de1_q    <= pix_de;
            prev_q   <= rd_data_q;
            if (win1_q) pix_rgb_out <= (rec_valid_q && hit) ? TRACE_RGB : BG_RGB;
            else        pix_rgb_out <= rgb1_q;
            pix_de_out <= de1_q;
        end
    end

endmodule

// File: tb/tb_wave_scope_plot.sv
// Directed bench for wave_scope_plot: capture/trigger timing, bank swap, trace rendering.
module tb_wave_scope_plot;

    localparam int          X0 = 64;
    localparam int          Y0 = 112;
    localparam logic [23:0] TR = 24'hFFFF00;
    localparam logic [23:0] BG = 24'h000000;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [7:0]  sample_in;
    logic        sample_valid;
    logic        freeze;
    logic        frame_start;
    logic        pix_de;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic [23:0] pix_rgb_in;
    logic [23:0] pix_rgb_out, pix_rgb_out4;
    logic        pix_de_out, pix_de_out4;
    logic        cap_busy, cap_busy4;
    logic        rec_valid, rec_valid4;

    int n_pass  = 0;
    int n_total = 0;

    always #10 sys_clk = ~sys_clk;

    wave_scope_plot u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sample_in(sample_in),
        .sample_valid(sample_valid), .freeze(freeze), .frame_start(frame_start),
        .pix_de(pix_de), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb_in(pix_rgb_in),
        .pix_rgb_out(pix_rgb_out), .pix_de_out(pix_de_out), .cap_busy(cap_busy),
        .rec_valid(rec_valid)
    );

    wave_scope_plot #(.DECIM(4)) u_dut4 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sample_in(sample_in),
        .sample_valid(sample_valid), .freeze(freeze), .frame_start(frame_start),
        .pix_de(pix_de), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb_in(pix_rgb_in),
        .pix_rgb_out(pix_rgb_out4), .pix_de_out(pix_de_out4), .cap_busy(cap_busy4),
        .rec_valid(rec_valid4)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Presents column x-1 then x on row y, returns the composited pixel for column x.
    task automatic probe(input int x, input int y, input logic [23:0] rgb,
                         output logic [23:0] got, output logic [23:0] got4);
        pix_de = 1'b1; pix_x = 12'(x - 1); pix_y = 12'(y); pix_rgb_in = rgb;
        tick();
        pix_x = 12'(x);
        tick();
        pix_de = 1'b0; pix_x = 12'd0; pix_y = 12'd0; pix_rgb_in = 24'd0;
        tick();
        got  = pix_rgb_out;
        got4 = pix_rgb_out4;
    endtask

    logic [23:0] g, g4;
    logic [23:0] s_rgb [8];
    logic        s_de  [8];

    initial begin
        sys_rst = 1'b1; sample_in = 8'd0; sample_valid = 1'b0; freeze = 1'b0;
        frame_start = 1'b0; pix_de = 1'b0; pix_x = 12'd0; pix_y = 12'd0;
        pix_rgb_in = 24'd0;
        tick(); tick();
        chk("reset_busy", 24'(cap_busy), 24'd0);
        chk("reset_recv", 24'(rec_valid), 24'd0);
        chk("reset_rgb", pix_rgb_out, 24'd0);
        chk("reset_de", 24'(pix_de_out), 24'd0);
        sys_rst = 1'b0;

        // Reset in the middle of a capture (word 200 just written)
        pix_de = 1'b1; pix_rgb_in = 24'hABCDEF;
        for (int n = 0; n <= 328; n++) begin
            sample_in = 8'(n); sample_valid = 1'b1;
            tick();
        end
        chk("mid_busy", 24'(cap_busy), 24'd1);
        chk("mid_pass", pix_rgb_out, 24'hABCDEF);
        sys_rst = 1'b1; sample_valid = 1'b0;
        tick();
        sys_rst = 1'b0;
        chk("rst_busy", 24'(cap_busy), 24'd0);
        chk("rst_recv", 24'(rec_valid), 24'd0);
        chk("rst_rgb", pix_rgb_out, 24'd0);
        chk("rst_de", 24'(pix_de_out), 24'd0);
        pix_de = 1'b0; pix_rgb_in = 24'd0;
        probe(X0 + 5, Y0 + 10, 24'h123456, g, g4);
        chk("rst_win_bg", g, BG);
        probe(X0 - 1, Y0 + 10, 24'h123456, g, g4);
        chk("rst_outside", g, 24'h123456);

        // Ramp 0..255; frame_start mid-capture and on the final write must not swap
        for (int n = 0; n < 2200; n++) begin
            sample_in = 8'(n); sample_valid = 1'b1;
            frame_start = (n == 300) || (n == 639);
            tick();
            if (n == 638)  chk("ramp_busy_638", 24'(cap_busy), 24'd1);
            if (n == 639)  chk("ramp_busy_639", 24'(cap_busy), 24'd0);
            if (n == 700)  chk("ramp_recv_pre", 24'(rec_valid), 24'd0);
            if (n == 2171) chk("dec4_busy_2171", 24'(cap_busy4), 24'd1);
            if (n == 2172) chk("dec4_busy_2172", 24'(cap_busy4), 24'd0);
        end
        sample_valid = 1'b0; frame_start = 1'b0;
        chk("ramp_recv_wait", 24'(rec_valid), 24'd0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("ramp_recv_swap", 24'(rec_valid), 24'd1);
        chk("dec4_recv_swap", 24'(rec_valid4), 24'd1);
        probe(X0, Y0 + 127, 24'h0, g, g4);
        chk("ramp_w0_hit", g, TR);
        probe(X0, Y0 + 126, 24'h0, g, g4);
        chk("ramp_w0_miss", g, BG);
        probe(X0 + 127, Y0, 24'h0, g, g4);
        chk("ramp_w127_hit", g, TR);
        probe(X0 + 127, Y0 + 2, 24'h0, g, g4);
        chk("ramp_w127_miss", g, BG);
        probe(X0 + 129, Y0 + 255, 24'h0, g, g4);
        chk("ramp_w128_hit", g, TR);
        probe(X0 + 129, Y0 + 253, 24'h0, g, g4);
        chk("ramp_w128_miss", g, BG);
        probe(X0 + 1, Y0 + 123, 24'h0, g, g4);
        chk("dec4_c1_top", g4, TR);
        probe(X0 + 1, Y0 + 122, 24'h0, g, g4);
        chk("dec4_c1_above", g4, BG);
        probe(X0 + 1, Y0 + 128, 24'h0, g, g4);
        chk("dec4_c1_below", g4, BG);
        probe(X0 + 33, Y0 + 251, 24'h0, g, g4);
        chk("dec4_c33_hit", g4, TR);
        probe(X0 + 33, Y0 + 250, 24'h0, g, g4);
        chk("dec4_c33_miss", g4, BG);

        // Constant 50: only the timeout can trigger, on the 4096th valid sample
        for (int i = 0; i < 4607; i++) begin
            sample_in = 8'd50; sample_valid = 1'b1;
            tick();
            if (i == 4605) chk("const_busy_4605", 24'(cap_busy), 24'd1);
            if (i == 4606) chk("const_busy_4606", 24'(cap_busy), 24'd0);
        end
        sample_valid = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        probe(X0 + 10, Y0 + 205, 24'h0, g, g4);
        chk("const_hit", g, TR);
        probe(X0 + 10, Y0 + 204, 24'h0, g, g4);
        chk("const_miss", g, BG);
        probe(X0, Y0 + 205, 24'h0, g, g4);
        chk("const_col0", g, TR);

        // Alternating 0/255 with freeze raised mid-capture
        for (int m = 0; m < 600; m++) begin
            sample_in = (m % 2 == 1) ? 8'd255 : 8'd0; sample_valid = 1'b1;
            freeze = (m >= 100);
            tick();
            if (m == 511) chk("alt_busy_511", 24'(cap_busy), 24'd1);
            if (m == 512) chk("alt_busy_512", 24'(cap_busy), 24'd0);
        end
        sample_valid = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick(); tick(); tick();
        chk("frz_hold_busy", 24'(cap_busy), 24'd0);
        probe(X0, Y0, 24'h0, g, g4);
        chk("alt_c0_top", g, TR);
        probe(X0, Y0 + 255, 24'h0, g, g4);
        chk("alt_c0_bot", g, BG);
        probe(X0 + 1, Y0 + 255, 24'h0, g, g4);
        chk("alt_c1_bot", g, TR);
        probe(X0 + 1, Y0, 24'h0, g, g4);
        chk("alt_c1_top", g, TR);
        probe(X0 + 300, Y0 + 128, 24'h0, g, g4);
        chk("alt_c300_mid", g, TR);
        probe(X0 + 511, Y0 + 255, 24'h0, g, g4);
        chk("alt_c511_bot", g, TR);
        probe(X0 + 512, Y0 + 10, 24'h00AA01, g, g4);
        chk("out_right", g, 24'h00AA01);
        probe(X0 + 100, Y0 + 256, 24'h00AA02, g, g4);
        chk("out_below", g, 24'h00AA02);
        probe(X0 + 100, Y0 - 1, 24'h00AA03, g, g4);
        chk("out_above", g, 24'h00AA03);

        // Passthrough stream: pix_rgb_out and pix_de_out trail inputs by 2 cycles
        for (int i = 0; i < 8; i++) begin
            s_rgb[i] = 24'(i * 24'h010203 + 24'h000005);
            s_de[i]  = (i % 3 != 0);
            pix_x = 12'd10; pix_y = 12'd10; pix_de = s_de[i]; pix_rgb_in = s_rgb[i];
            tick();
            if (i >= 1) begin
                chk("pass_rgb", pix_rgb_out, s_rgb[i-1]);
                chk("pass_de", 24'(pix_de_out), 24'(s_de[i-1]));
            end
        end
        pix_de = 1'b0; pix_rgb_in = 24'd0;

        chk("frz_still_idle", 24'(cap_busy), 24'd0);
        freeze = 1'b0;
        tick();
        chk("frz_rearm", 24'(cap_busy), 24'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
